mult_pipe_latch: RTL and testbench

Parametrised pipeline latch between multiplier stages, successor to the fixed 8-lane, always-enabled stage latch. Carries LANES data lanes of WIDTH bits, one auxiliary register value and the in-flight instruction word. Adds a valid/ready handshake with a 2-entry skid buffer, so downstream back-pressure stalls the stage without loss, plus a synchronous flush that inserts a bubble.

---
 rtl/mult_pipe_latch.sv | 134 +++++++++++++
 tb/tb_mult_pipe_latch.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe_latch.sv
// mult_pipe_latch
//   Pipeline latch between multiplier stages. Carries LANES data lanes of
//   WIDTH bits, one auxiliary register value and the instruction word, with a
//   valid/ready handshake backed by a 2-entry (main + skid) buffer.
//
// Ports
//   clock      : rising-edge clock
//   reset      : synchronous active-high reset, overrides everything
//   flush      : synchronous discard of all held entries
//   in_valid   : upstream offers an entry
//   in_ready   : latch accepts an entry this cycle (combinational)
//   in_lanes   : lane k at bits [k*WIDTH +: WIDTH]
//   in_reg     : auxiliary register value
//   in_ins     : instruction word
//   out_valid  : main entry valid
//   out_ready  : downstream accepts the main entry
//   out_lanes  : same packing as in_lanes
//   out_reg    : auxiliary register value of main entry
//   out_ins    : instruction word of main entry, NOP_INS when empty
//   occupancy  : number of held entries (0..2)
module mult_pipe_latch #(
    parameter int unsigned          WIDTH     = 32,
    parameter int unsigned          LANES     = 8,
    parameter int unsigned          INS_WIDTH = 32,
    parameter logic [INS_WIDTH-1:0] NOP_INS   = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_lanes,
    input  logic [WIDTH-1:0]       in_reg,
    input  logic [INS_WIDTH-1:0]   in_ins,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_lanes,
    output logic [WIDTH-1:0]       out_reg,
    output logic [INS_WIDTH-1:0]   out_ins,
    output logic [1:0]             occupancy
);

    // EMPTY: nothing held; ONE: main valid; FULL: main and skid valid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [LANES*WIDTH-1:0] main_lanes_q;
    logic [WIDTH-1:0]       main_reg_q;
    logic [INS_WIDTH-1:0]   main_ins_q;
    logic [LANES*WIDTH-1:0] skid_lanes_q;
    logic [WIDTH-1:0]       skid_reg_q;
    logic [INS_WIDTH-1:0]   skid_ins_q;

    logic in_fire;
    logic out_fire;

    always_comb begin
        in_ready  = (state_q != FULL) && !flush && !reset;
        out_valid = (state_q != EMPTY);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        unique case (state_q)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign out_lanes = main_lanes_q;
    assign out_reg   = main_reg_q;
    assign out_ins   = main_ins_q;

    // main_ins_q is forced to NOP_INS whenever the latch drains, so out_ins
    // needs no combinational mux on out_valid. Lanes and reg simply hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= EMPTY;
            main_lanes_q <= '0;
            main_reg_q   <= '0;
            main_ins_q   <= NOP_INS;
            skid_lanes_q <= '0;
            skid_reg_q   <= '0;
            skid_ins_q   <= '0;
        end else if (flush) begin
            state_q    <= EMPTY;
            main_ins_q <= NOP_INS;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_q      <= ONE;
                        main_lanes_q <= in_lanes;
                        main_reg_q   <= in_reg;
                        main_ins_q   <= in_ins;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_lanes_q <= in_lanes;
                        main_reg_q   <= in_reg;
                        main_ins_q   <= in_ins;
                    end else if (in_fire) begin
                        // Downstream stalled: park the younger entry in skid.
                        state_q      <= FULL;
                        skid_lanes_q <= in_lanes;
                        skid_reg_q   <= in_reg;
                        skid_ins_q   <= in_ins;
                    end else if (out_fire) begin
                        state_q    <= EMPTY;
                        main_ins_q <= NOP_INS;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_q      <= ONE;
                        main_lanes_q <= skid_lanes_q;
                        main_reg_q   <= skid_reg_q;
                        main_ins_q   <= skid_ins_q;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    main_ins_q <= NOP_INS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_pipe_latch.sv
module tb_mult_pipe_latch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clock = 1'b0;
    logic reset, flush, in_valid, out_ready;
    logic [31:0] in_ins;

    // DUT0: 8 x 32, DUT1: 1 x 16, DUT2: 4 x 64 (all share handshake inputs)
    logic [255:0] in_lanes0, out_lanes0;
    logic [31:0]  in_reg0, out_reg0;
    logic [15:0]  in_lanes1, out_lanes1, in_reg1, out_reg1;
    logic [255:0] in_lanes2, out_lanes2;
    logic [63:0]  in_reg2, out_reg2;
    logic [31:0]  out_ins0, out_ins1, out_ins2;
    logic         in_ready0, in_ready1, in_ready2;
    logic         out_valid0, out_valid1, out_valid2;
    logic [1:0]   occ0, occ1, occ2;

    typedef struct {
        int seed;
        int ins;
    } ent_t;

    ent_t sb[$];
    int   got[$];
    int   want[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    int   cur_seed = 0;
    int   acc = 0;

    always #5 clock = ~clock;

    mult_pipe_latch #(.WIDTH(32), .LANES(8), .INS_WIDTH(32), .NOP_INS(NOP)) dut0 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_lanes(in_lanes0), .in_reg(in_reg0), .in_ins(in_ins),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_lanes(out_lanes0), .out_reg(out_reg0), .out_ins(out_ins0),
        .occupancy(occ0)
    );

    mult_pipe_latch #(.WIDTH(16), .LANES(1), .INS_WIDTH(32), .NOP_INS(NOP)) dut1 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_lanes(in_lanes1), .in_reg(in_reg1), .in_ins(in_ins),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_lanes(out_lanes1), .out_reg(out_reg1), .out_ins(out_ins1),
        .occupancy(occ1)
    );

    mult_pipe_latch #(.WIDTH(64), .LANES(4), .INS_WIDTH(32), .NOP_INS(NOP)) dut2 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_lanes(in_lanes2), .in_reg(in_reg2), .in_ins(in_ins),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_lanes(out_lanes2), .out_reg(out_reg2), .out_ins(out_ins2),
        .occupancy(occ2)
    );

    // Lane k of an entry: low word seed+k, high word seed^DEADBEEF (64-bit lanes).
    function automatic logic [63:0] lv(input int seed, input int k);
        return {32'(seed) ^ 32'hDEAD_BEEF, 32'(seed + k)};
    endfunction

    function automatic logic [63:0] rv(input int seed);
        return {32'(seed + 32'h55), 32'(seed) ^ 32'h0F0F_0F0F};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_payload(input int seed, input int ins);
        logic [63:0] t;
        for (int k = 0; k < 8; k++) begin
            t = lv(seed, k);
            in_lanes0[k*32 +: 32] = t[31:0];
        end
        for (int k = 0; k < 4; k++) begin
            t = lv(seed, k);
            in_lanes2[k*64 +: 64] = t;
        end
        t = lv(seed, 0);
        in_lanes1 = t[15:0];
        t = rv(seed);
        in_reg0 = t[31:0];
        in_reg1 = t[15:0];
        in_reg2 = t;
        cur_seed = seed;
        in_ins = 32'(ins);
    endtask

    // Inputs change at posedge+2; acceptance is decided at posedge+8.
    task automatic step();
        #6;
        acc = 0;
        if (in_valid && in_ready0) begin
            sb.push_back('{cur_seed, int'(in_ins)});
            acc = 1;
        end
        @(posedge clock);
        #2;
    endtask

    task automatic send(input int seed, input int ins);
        set_payload(seed, ins);
        in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 20 && acc == 0; i++) step();
        chk("send_accepted", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic check_got(input string nm);
        chk({nm, "_count"}, 64'(got.size()), 64'(want.size()));
        for (int i = 0; i < want.size() && i < got.size(); i++)
            chk({nm, "_order"}, 64'(got[i]), 64'(want[i]));
        got.delete();
        want.delete();
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_occ0"}, 64'(occ0), 64'd0);
        chk({nm, "_occ1"}, 64'(occ1), 64'd0);
        chk({nm, "_occ2"}, 64'(occ2), 64'd0);
        chk({nm, "_valid0"}, 64'(out_valid0), 64'd0);
        chk({nm, "_ins0"}, 64'(out_ins0), 64'(NOP));
        chk({nm, "_ins1"}, 64'(out_ins1), 64'(NOP));
        chk({nm, "_ins2"}, 64'(out_ins2), 64'(NOP));
        for (int k = 0; k < 8; k++) chk({nm, "_lane0"}, 64'(out_lanes0[k*32 +: 32]), 64'd0);
        for (int k = 0; k < 4; k++) chk({nm, "_lane2"}, out_lanes2[k*64 +: 64], 64'd0);
        chk({nm, "_lane1"}, 64'(out_lanes1), 64'd0);
        chk({nm, "_reg0"}, 64'(out_reg0), 64'd0);
        chk({nm, "_reg1"}, 64'(out_reg1), 64'd0);
        chk({nm, "_reg2"}, out_reg2, 64'd0);
    endtask

    // Scoreboard monitor: queue size is the model occupancy; its head is the
    // entry every DUT must present.
    always @(negedge clock) begin : mon
        int n;
        ent_t e;
        logic [63:0] t;
        logic exp_v, exp_r;
        if (mon_en) begin
            n = sb.size();
            exp_v = (n > 0);
            exp_r = (n < 2) && !flush && !reset;
            chk("occ0", 64'(occ0), 64'(n));
            chk("occ1", 64'(occ1), 64'(n));
            chk("occ2", 64'(occ2), 64'(n));
            chk("out_valid0", 64'(out_valid0), 64'(exp_v));
            chk("out_valid1", 64'(out_valid1), 64'(exp_v));
            chk("out_valid2", 64'(out_valid2), 64'(exp_v));
            chk("in_ready0", 64'(in_ready0), 64'(exp_r));
            chk("in_ready1", 64'(in_ready1), 64'(exp_r));
            chk("in_ready2", 64'(in_ready2), 64'(exp_r));
            if (exp_v) begin
                e = sb[0];
                chk("out_ins0", 64'(out_ins0), 64'(32'(e.ins)));
                chk("out_ins1", 64'(out_ins1), 64'(32'(e.ins)));
                chk("out_ins2", 64'(out_ins2), 64'(32'(e.ins)));
                for (int k = 0; k < 8; k++) begin
                    t = lv(e.seed, k);
                    chk("out_lane0", 64'(out_lanes0[k*32 +: 32]), 64'(t[31:0]));
                end
                for (int k = 0; k < 4; k++) begin
                    t = lv(e.seed, k);
                    chk("out_lane2", out_lanes2[k*64 +: 64], t);
                end
                t = lv(e.seed, 0);
                chk("out_lane1", 64'(out_lanes1), 64'(t[15:0]));
                t = rv(e.seed);
                chk("out_reg0", 64'(out_reg0), 64'(t[31:0]));
                chk("out_reg1", 64'(out_reg1), 64'(t[15:0]));
                chk("out_reg2", out_reg2, t);
                if (out_ready) begin
                    got.push_back(int'(out_ins0));
                    sb.delete(0);
                end
            end else begin
                chk("idle_ins0", 64'(out_ins0), 64'(NOP));
                chk("idle_ins1", 64'(out_ins1), 64'(NOP));
                chk("idle_ins2", 64'(out_ins2), 64'(NOP));
            end
            if (flush || reset) sb.delete();
        end
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_payload(0, 0);
        @(posedge clock);
        #2;
        mon_en = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
        check_reset_outputs("reset");

        // First entry: 1-cycle latency, lane packing
        out_ready = 1'b1;
        send(32'h1000, 32'hA1);
        chk("stream_valid", 64'(out_valid0), 64'd1);
        chk("stream_lane7", 64'(out_lanes0[7*32 +: 32]), 64'h1007);
        chk("stream_w16_lane0", 64'(out_lanes1), 64'h1000);
        chk("stream_w64_lane3", out_lanes2[3*64 +: 64], {32'h1000 ^ 32'hDEAD_BEEF, 32'h1003});

        // Back-to-back stream
        for (int i = 0; i < 16; i++) begin
            send(32'h2000 + i * 16, i);
            chk("b2b_occ_le1", 64'(occ0 <= 2'd1), 64'd1);
        end
        step();
        step();
        want.push_back(32'hA1);
        for (int i = 0; i < 16; i++) want.push_back(i);
        check_got("stream");

        // Back-pressure: skid fill, stall, ordered drain
        send(32'h3000, 32'h10);
        out_ready = 1'b0;
        send(32'h3100, 32'h11);
        set_payload(32'h3200, 32'h12);
        in_valid = 1'b1;
        chk("bp_occ_full", 64'(occ0), 64'd2);
        chk("bp_in_ready_low", 64'(in_ready0), 64'd0);
        step();
        step();
        step();
        chk("bp_held_upstream", 64'(acc), 64'd0);
        out_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 10 && acc == 0; i++) step();
        chk("bp_refill_accept", 64'(acc), 64'd1);
        in_valid = 1'b0;
        step();
        step();
        step();
        want.push_back(32'h10);
        want.push_back(32'h11);
        want.push_back(32'h12);
        check_got("backpressure");

        // Flush while FULL with a simultaneous input offer
        out_ready = 1'b0;
        send(32'h4000, 32'h20);
        send(32'h4100, 32'h21);
        chk("flush_pre_occ", 64'(occ0), 64'd2);
        set_payload(32'h5500, 32'h55);
        in_valid = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", 64'(occ0), 64'd0);
        chk("flush_valid", 64'(out_valid0), 64'd0);
        chk("flush_ins", 64'(out_ins0), 64'(NOP));
        chk("flush_lane_hold", 64'(out_lanes0[31:0]), 64'h4000);
        out_ready = 1'b1;
        step();
        step();
        step();
        check_got("flush_full");

        // Flush in the same cycle the output fires: entry counts as delivered
        send(32'h6000, 32'h30);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        want.push_back(32'h30);
        check_got("flush_fire");

        // Reset during a full stall
        out_ready = 1'b0;
        send(32'h7000, 32'h40);
        send(32'h7100, 32'h41);
        chk("rst_pre_occ", 64'(occ0), 64'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_outputs("reset_mid");
        out_ready = 1'b1;
        send(32'h7200, 32'h42);
        chk("rst_after_valid", 64'(out_valid0), 64'd1);
        chk("rst_after_ins", 64'(out_ins0), 64'h42);
        step();
        step();
        want.push_back(32'h42);
        check_got("reset_mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
